// File: rtl/tap_delay_line_if.sv
// Sample stream bundle for tap_delay_line: input samples, delay select, delayed output.
interface tap_delay_line_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int DLY_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [DLY_W-1:0] dly;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             primed;

    modport master (
        output in_data, in_valid, dly,
        input  out_data, out_valid, primed
    );

    modport slave (
        input  in_data, in_valid, dly,
        output out_data, out_valid, primed
    );
endinterface

// File: rtl/tap_delay_line.sv
// Programmable sample delay line (0..DEPTH samples) advancing only on accepted samples.
// Define DLINE_FLUSH_EN to add the flush port, which clears storage and fill count.
module tap_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
`ifdef DLINE_FLUSH_EN
    input  logic flush,
`endif
    tap_delay_line_if.slave bus
);
    localparam int DLY_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [DLY_W-1:0] DEPTH_D = DLY_W'(DEPTH);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [DLY_W-1:0] fill;
    logic [DLY_W-1:0] d_eff;

    logic [DLY_W-1:0] dly_c;
    logic [DLY_W-1:0] d_m1;
    logic [WIDTH-1:0] tap;
    logic             shift_en;
    logic             clr_stages;
    logic             out_load;
    logic [DLY_W-1:0] fill_d;
    logic [DLY_W-1:0] d_eff_d;

    // Sample n-d_eff lives in stage[d_eff-1] before this edge's shift; d_eff=0 bypasses storage.
    always_comb begin
        d_m1 = d_eff - DLY_W'(1);
        if (d_eff == '0) begin
            tap = bus.in_data;
        end else begin
            tap = stage[d_m1[IDX_W-1:0]];
        end
    end

    // The clamped request is what gets compared, so an oversize dly does not retrigger every edge.
    always_comb begin
        dly_c      = (bus.dly > DEPTH_D) ? DEPTH_D : bus.dly;
        shift_en   = 1'b0;
        clr_stages = 1'b0;
        out_load   = 1'b0;
        fill_d     = fill;
        d_eff_d    = d_eff;
`ifdef DLINE_FLUSH_EN
        if (flush) begin
            clr_stages = 1'b1;
            fill_d     = '0;
        end else
`endif
        if (dly_c != d_eff) begin
            d_eff_d  = dly_c;
            shift_en = bus.in_valid;
            fill_d   = bus.in_valid ? DLY_W'(1) : '0;
        end else if (bus.in_valid) begin
            shift_en = 1'b1;
            fill_d   = (fill == DEPTH_D) ? fill : fill + DLY_W'(1);
            out_load = (fill >= d_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            fill        <= '0;
            d_eff       <= DEPTH_D;
        end else begin
            if (clr_stages) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage[i] <= '0;
                end
            end else if (shift_en) begin
                stage[0] <= bus.in_data;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
            if (out_load) begin
                out_data_q <= tap;
            end
            out_valid_q <= out_load;
            fill        <= fill_d;
            d_eff       <= d_eff_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.primed    = (fill >= d_eff);
endmodule

// File: doc/tap_delay_line.md
TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, sample width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 16, maximum delay in samples (2..256).
REQ-003 The block SHALL have localparam DLY_W = $clog2(DEPTH+1), the width of the delay select.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port in_data  input  WIDTH  sample in.
REQ-007 The block SHALL have port in_valid  input  1  sample-accept strobe; one sample per high cycle.
REQ-008 The block SHALL have port dly  input  DLY_W  requested delay in samples.
REQ-009 The block SHALL have port out_data  output  WIDTH  delayed sample, registered.
REQ-010 The block SHALL have port out_valid  output  1  one-cycle strobe marking a new out_data.
REQ-011 The block SHALL have port primed  output  1  high when fill count >= effective delay.

Function
REQ-012 Storage SHALL be a DEPTH-stage shift register that advances only on cycles with in_valid=1; stage0 takes in_data.
REQ-013 d_eff SHALL be a register holding min(dly, DEPTH); dly values above DEPTH clamp to DEPTH.
REQ-014 fill SHALL count accepted samples since the last reset, dly change or flush, saturating at DEPTH.
REQ-015 primed SHALL be combinational (fill >= d_eff).
REQ-016 Numbering accepted samples n=0,1,..., on the edge accepting sample n the block SHALL set out_data to sample n-d_eff and out_valid=1 if n >= d_eff; otherwise out_valid=0.
REQ-017 Latency SHALL be exactly 1 clk from the accepting edge to out_valid; with d_eff=0, out_data SHALL equal the accepted sample.
REQ-018 On cycles with in_valid=0, out_valid SHALL be 0, and out_data, storage and fill SHALL hold.
REQ-019 If dly differs from d_eff at an edge, the block SHALL load d_eff with clamp(dly) and clear fill, and out_valid SHALL be 0 on that edge.
REQ-020 If in_valid=1 on that same edge, the sample SHALL still shift in and count as n=0 (fill=1).
REQ-021 Storage contents SHALL NOT be cleared on a dly change.
REQ-022 Event priority SHALL be rst > flush (if compiled) > dly change > in_valid.

Reset
REQ-023 On rst=1, all stages SHALL go to 0, out_data to 0, out_valid to 0, fill to 0 and d_eff to DEPTH; primed is then 0.
REQ-024 A dly differing from DEPTH on the first edge after reset SHALL be handled per REQ-019.
REQ-025 rst mid-stream SHALL discard all in-flight samples; in_valid SHALL be ignored while rst=1.

Configuration
REQ-026 With macro DLINE_FLUSH_EN defined, the block SHALL add port flush  input  1.
REQ-027 With DLINE_FLUSH_EN defined, flush=1 SHALL zero all stages, clear fill, force out_valid to 0 and ignore in_valid, while keeping d_eff and out_data.
REQ-028 Without DLINE_FLUSH_EN, the flush port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Verification (WIDTH=8, DEPTH=4)
REQ-029 Reset, dly=2, then back-to-back samples 0x10,0x11,0x12,0x13 -> out_valid 0,0,1,1 and out_data 0x10 then 0x11; primed rises after the second sample.
REQ-030 dly=0, single sample 0xA5 -> out_valid=1 with out_data=0xA5 exactly 1 clk later.
REQ-031 dly=1, samples 0x01,0x02,0x03 with two idle cycles between each -> out_valid pulses only after 0x02 (data 0x01) and after 0x03 (data 0x02), and out_data holds during idle cycles.
REQ-032 dly=7 -> d_eff=4; first out_valid on the 5th sample, carrying the 1st sample.
REQ-033 Primed with dly=2, switch to dly=1 alongside in_valid -> out_valid=0 that edge and fill=1; next sample yields out_valid=1 with out_data equal to the sample accepted on the switch edge.
REQ-034 DLINE_FLUSH_EN: primed at dly=2, flush pulse together with in_valid -> out_valid=0, primed=0, sample dropped; two further samples are needed before out_valid returns.
